// File: rtl/sample_dma_receiver.sv
// Receive side of the sampler DMA path: writes returned burst beats into the sample buffer,
// tracks outstanding requests and flags round completion once everything has drained.
module sample_dma_receiver #(
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned ID_W      = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stop,
    input  logic                                 dma_req_accepted,
    input  logic [DATA_W-1:0]                    dma_data,
    input  logic [ID_W-1:0]                      dma_data_id,
    input  logic                                 dma_data_valid,
    input  logic                                 dma_data_last,
    output logic                                 dma_data_ready,
    input  logic                                 last_request_sent,
    input  logic [ID_W-1:0]                      last_request_id,
    output logic                                 all_samples_received,
    output logic                                 buf_wr_en,
    output logic [ID_W+$clog2(BURST_LEN)-1:0]    buf_wr_addr,
    output logic [DATA_W-1:0]                    buf_wr_data,
    input  logic                                 buf_wr_ready,
    output logic [ID_W:0]                        outstanding_cnt,
    output logic                                 rx_error
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ID_W:0] CNT_MAX = {1'b1, {ID_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StCollect, StArmed, StDone} state_e;

    state_e            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   last_req_id;
    logic              beat_accept;
    logic              last_accept;
    logic              beat_err;
    logic              cnt_err;
    logic [ID_W:0]     out_next;

    assign dma_data_ready = buf_wr_ready & ~reset & ~stop;
    assign beat_accept    = dma_data_valid & dma_data_ready;
    assign last_accept    = beat_accept & dma_data_last;

    // Protocol checks: interleaved ID mid-burst, or last not aligned with the final beat.
    always_comb begin
        beat_err = 1'b0;
        if (beat_accept) begin
            if ((beat_cnt != '0) && (dma_data_id != cur_id)) begin
                beat_err = 1'b1;
            end
            if (dma_data_last != (beat_cnt == LAST_BEAT)) begin
                beat_err = 1'b1;
            end
        end
    end

    always_comb begin
        out_next = outstanding_cnt;
        cnt_err  = 1'b0;
        if (dma_req_accepted && !last_accept) begin
            if (outstanding_cnt == CNT_MAX) begin
                cnt_err = 1'b1;
            end else begin
                out_next = outstanding_cnt + 1'b1;
            end
        end else if (last_accept && !dma_req_accepted) begin
            if (outstanding_cnt == '0) begin
                cnt_err = 1'b1;
            end else begin
                out_next = outstanding_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            state                <= StIdle;
            beat_cnt             <= '0;
            cur_id               <= '0;
            last_req_id          <= '0;
            outstanding_cnt      <= '0;
            rx_error             <= 1'b0;
            buf_wr_en            <= 1'b0;
            buf_wr_addr          <= '0;
            buf_wr_data          <= '0;
            all_samples_received <= 1'b0;
        end else begin
            buf_wr_en <= beat_accept;
            if (beat_accept) begin
                buf_wr_addr <= {dma_data_id, beat_cnt};
                buf_wr_data <= dma_data;
                beat_cnt    <= dma_data_last ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0) begin
                    cur_id <= dma_data_id;
                end
            end
            outstanding_cnt <= out_next;
            if (beat_err || cnt_err) begin
                rx_error <= 1'b1;
            end
            if (last_request_sent) begin
                last_req_id <= last_request_id;
            end

            all_samples_received <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (last_request_sent) begin
                        state <= StArmed;
                    end else if (dma_req_accepted) begin
                        state <= StCollect;
                    end
                end
                StCollect: begin
                    if (last_request_sent) begin
                        state <= StArmed;
                    end
                end
                StArmed: begin
                    // Post-update count, so a final last beat in this cycle completes the round.
                    if (out_next == '0) begin
                        state                <= StDone;
                        all_samples_received <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_dma_receiver.sv
// Bench for sample_dma_receiver: directed scenarios plus random traffic, all checked every cycle
// against a behavioural model of beat placement, request accounting and round completion.
module tb_sample_dma_receiver;

    localparam int BL = 64;
    localparam int IW = 6;
    localparam int DW = 32;
    localparam int AW = IW + 6;

    logic          clk = 1'b0;
    logic          reset, stop, dma_req_accepted, dma_data_valid, dma_data_last;
    logic          last_request_sent, buf_wr_ready;
    logic [DW-1:0] dma_data;
    logic [IW-1:0] dma_data_id, last_request_id;
    logic          dma_data_ready, all_samples_received, buf_wr_en, rx_error;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic [IW:0]   outstanding_cnt;

    sample_dma_receiver #(.BURST_LEN(BL), .ID_W(IW), .DATA_W(DW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stop                 (stop),
        .dma_req_accepted     (dma_req_accepted),
        .dma_data             (dma_data),
        .dma_data_id          (dma_data_id),
        .dma_data_valid       (dma_data_valid),
        .dma_data_last        (dma_data_last),
        .dma_data_ready       (dma_data_ready),
        .last_request_sent    (last_request_sent),
        .last_request_id      (last_request_id),
        .all_samples_received (all_samples_received),
        .buf_wr_en            (buf_wr_en),
        .buf_wr_addr          (buf_wr_addr),
        .buf_wr_data          (buf_wr_data),
        .buf_wr_ready         (buf_wr_ready),
        .outstanding_cnt      (outstanding_cnt),
        .rx_error             (rx_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    int          m_out, m_pos, m_id, m_addr;
    bit          m_err, m_en, m_pulse, m_armed;
    logic [31:0] m_data;
    int          cyc = 0;

    // Observed activity, cleared/read only on posedge to avoid racing the negedge checker
    int obs_writes, obs_pulses, first_addr, last_addr, last_wr_cyc, pulse_cyc;

    always @(posedge clk) begin
        bit rdy, acc, inc, dec;
        int nout;
        cyc++;
        rdy = buf_wr_ready && !reset && !stop;
        chk("dma_data_ready", dma_data_ready, rdy);
        if (reset || stop) begin
            m_out = 0; m_pos = 0; m_id = 0; m_addr = 0; m_data = '0;
            m_err = 0; m_en = 0; m_pulse = 0; m_armed = 0;
        end else begin
            acc  = dma_data_valid && rdy;
            m_en = acc;
            if (acc) begin
                m_addr = int'(dma_data_id) * BL + m_pos;
                m_data = dma_data;
                if (m_pos == 0) m_id = int'(dma_data_id);
                else if (int'(dma_data_id) != m_id) m_err = 1;
                if (dma_data_last) begin
                    if (m_pos != BL - 1) m_err = 1;
                    m_pos = 0;
                end else begin
                    if (m_pos == BL - 1) m_err = 1;
                    m_pos = (m_pos + 1) % BL;
                end
            end
            inc  = dma_req_accepted;
            dec  = acc && dma_data_last;
            nout = m_out + int'(inc) - int'(dec);
            if (nout > (1 << IW)) begin nout = 1 << IW; m_err = 1; end
            if (nout < 0) begin nout = 0; m_err = 1; end
            // Round completion: once armed, done when the drained count reaches zero;
            // the completion cycle itself ignores a new last_request_sent.
            if (m_pulse) m_pulse = 0;
            else if (m_armed) begin
                if (nout == 0) begin m_pulse = 1; m_armed = 0; end
            end else if (last_request_sent) m_armed = 1;
            m_out = nout;
        end
    end

    always @(negedge clk) begin
        chk("buf_wr_en", buf_wr_en, m_en);
        chk("buf_wr_addr", buf_wr_addr, m_addr);
        chk("buf_wr_data", buf_wr_data, m_data);
        chk("outstanding_cnt", outstanding_cnt, m_out);
        chk("rx_error", rx_error, m_err);
        chk("all_samples_received", all_samples_received, m_pulse);
        if (buf_wr_en) begin
            obs_writes++;
            if (obs_writes == 1) first_addr = int'(buf_wr_addr);
            last_addr   = int'(buf_wr_addr);
            last_wr_cyc = cyc;
        end
        if (all_samples_received) begin
            obs_pulses++;
            pulse_cyc = cyc;
        end
    end

    task automatic idle_inputs();
        reset = 0; stop = 0; dma_req_accepted = 0; dma_data_valid = 0; dma_data_last = 0;
        last_request_sent = 0; buf_wr_ready = 1; dma_data = '0; dma_data_id = '0;
        last_request_id = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic clear_obs();
        @(posedge clk);
        obs_writes = 0; obs_pulses = 0; first_addr = -1; last_addr = -1;
        last_wr_cyc = -1; pulse_cyc = -2;
    endtask

    task automatic pulse_req(input bit with_last, input int lrid);
        @(negedge clk);
        dma_req_accepted  = 1;
        last_request_sent = with_last;
        last_request_id   = IW'(lrid);
        @(negedge clk);
        dma_req_accepted  = 0;
        last_request_sent = 0;
    endtask

    // Sends nbeats beats; last is raised on beat index last_at (never if out of range)
    task automatic send_burst(input int id, input int nbeats, input int last_at, input bit toggle);
        int b = 0;
        bit r = 0;
        while (b < nbeats) begin
            @(negedge clk);
            r = toggle ? ~r : 1'b1;
            buf_wr_ready   = r;
            dma_data_valid = 1;
            dma_data_id    = IW'(id);
            dma_data       = $urandom;
            dma_data_last  = (b == last_at);
            if (r) b++;
        end
        @(negedge clk);
        dma_data_valid = 0;
        dma_data_last  = 0;
        buf_wr_ready   = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("reset_outstanding", outstanding_cnt, 0);
        chk("reset_rx_error", rx_error, 0);
        chk("reset_wr_en", buf_wr_en, 0);
        chk("reset_addr", buf_wr_addr, 0);

        // One request, id 5, last_request_sent with the accept
        clear_obs();
        pulse_req(1, 5);
        send_burst(5, 64, 63, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("t1_writes", obs_writes, 64);
        chk("t1_first_addr", first_addr, 'h140);
        chk("t1_last_addr", last_addr, 'h17F);
        chk("t1_pulses", obs_pulses, 1);
        chk("t1_pulse_cycle", pulse_cyc, last_wr_cyc);
        chk("t1_rx_error", rx_error, 0);

        // Three requests, completion order 3,1,2
        do_reset();
        clear_obs();
        pulse_req(0, 0);
        pulse_req(0, 0);
        pulse_req(1, 3);
        @(posedge clk);
        chk("t2_outstanding3", outstanding_cnt, 3);
        send_burst(3, 64, 63, 0);
        send_burst(1, 64, 63, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("t2_no_early_pulse", obs_pulses, 0);
        chk("t2_outstanding1", outstanding_cnt, 1);
        send_burst(2, 64, 63, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("t2_pulses", obs_pulses, 1);
        chk("t2_pulse_after_id2", pulse_cyc, last_wr_cyc);
        chk("t2_outstanding0", outstanding_cnt, 0);

        // last_request_sent with nothing outstanding
        do_reset();
        clear_obs();
        @(negedge clk);
        last_request_sent = 1;
        @(negedge clk);
        last_request_sent = 0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        chk("t3_pulses", obs_pulses, 1);
        chk("t3_writes", obs_writes, 0);

        // buf_wr_ready toggling during the burst
        do_reset();
        clear_obs();
        pulse_req(1, 9);
        send_burst(9, 64, 63, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk("t4_writes", obs_writes, 64);
        chk("t4_last_addr", last_addr, 9 * 64 + 63);
        chk("t4_pulses", obs_pulses, 1);
        chk("t4_rx_error", rx_error, 0);

        // Early last on beat 10, then a short burst to show beat count restarted
        do_reset();
        clear_obs();
        pulse_req(0, 0);
        pulse_req(0, 0);
        send_burst(7, 11, 10, 0);
        @(posedge clk);
        chk("t5_rx_error", rx_error, 1);
        chk("t5_outstanding", outstanding_cnt, 1);
        send_burst(7, 2, 1, 0);
        @(posedge clk);
        chk("t5_restart_addr", last_addr, 'h1C1);
        chk("t5_rx_error_sticky", rx_error, 1);
        @(negedge clk);
        stop = 1;
        @(negedge clk);
        stop = 0;
        chk("t5_stop_clears", rx_error, 0);

        // Stop mid-burst at beat 30 with two outstanding
        do_reset();
        clear_obs();
        pulse_req(0, 0);
        pulse_req(1, 4);
        send_burst(4, 30, -1, 0);
        @(negedge clk);
        dma_data_valid = 1;
        dma_data_id    = 4;
        dma_data       = 32'hdead_beef;
        stop           = 1;
        @(negedge clk);
        stop           = 0;
        dma_data_valid = 0;
        chk("t6_outstanding", outstanding_cnt, 0);
        chk("t6_wr_en", buf_wr_en, 0);
        chk("t6_data", buf_wr_data, 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        chk("t6_no_pulse", obs_pulses, 0);

        // Outstanding counter saturation
        do_reset();
        @(negedge clk);
        dma_req_accepted = 1;
        repeat (65) @(negedge clk);
        dma_req_accepted = 0;
        chk("t7_saturated", outstanding_cnt, 64);
        chk("t7_rx_error", rx_error, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stop              = ($urandom_range(0, 299) == 0);
            dma_req_accepted  = ($urandom_range(0, 15) == 0);
            last_request_sent = ($urandom_range(0, 59) == 0);
            last_request_id   = IW'($urandom);
            dma_data_valid    = $urandom_range(0, 1) != 0;
            buf_wr_ready      = $urandom_range(0, 3) != 0;
            dma_data          = $urandom;
            if (m_pos == 0 || $urandom_range(0, 99) == 0) dma_data_id = IW'($urandom_range(0, 3));
            else dma_data_id = IW'(m_id);
            if (m_pos == BL - 1) dma_data_last = $urandom_range(0, 19) != 0;
            else dma_data_last = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
